// File: rtl/my_iir_tran_core.sv
// Second-order transposed direct-form-II IIR with serial coefficient load.
// Datapath keeps yacc at full Q.14 precision; only the registered output is scaled to Q1.15.
module my_iir_tran_core (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic signed [15:0] in,
  input  logic signed [15:0] cina,
  input  logic signed [15:0] cinb,
  output logic signed [15:0] out,
  output logic signed [31:0] outa1w,
  output logic signed [31:0] outb1w,
  output logic signed [31:0] outc1w,
  output logic signed [31:0] del0w,
  output logic signed [31:0] del2w,
  output logic signed [31:0] del3w,
  output logic signed [15:0] coeff_b0w
);

  logic signed [15:0] a_q [3];
  logic signed [15:0] b_q [3];
  logic signed [31:0] s1_q, s1_d;
  logic signed [31:0] s2_q, s2_d;
  logic signed [15:0] out_q, out_d;
  logic        [1:0]  idx_q, idx_d;
  logic               wr_en_s;

  logic signed [31:0] p_b0_s, p_b1_s, p_b2_s;
  logic signed [31:0] yacc_s, fb1_s, fb2_s, mid1_s, mid2_s;

  function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
    if (v > 34'sd2147483647) begin
      sat32 = 32'sh7fffffff;
    end else if (v < -34'sd2147483648) begin
      sat32 = 32'sh80000000;
    end else begin
      sat32 = v[31:0];
    end
  endfunction

  // Scales a Q.28 feedback product back to Q.14 before saturating.
  function automatic logic signed [31:0] fb_scale(input logic signed [47:0] v);
    logic signed [47:0] sh;
    sh = v >>> 5'd14;
    if (sh > 48'sd2147483647) begin
      fb_scale = 32'sh7fffffff;
    end else if (sh < -48'sd2147483648) begin
      fb_scale = 32'sh80000000;
    end else begin
      fb_scale = sh[31:0];
    end
  endfunction

  function automatic logic signed [15:0] sat_out(input logic signed [31:0] v);
    logic signed [31:0] sh;
    sh = v >>> 5'd14;
    if (sh > 32'sd32767) begin
      sat_out = 16'sh7fff;
    end else if (sh < -32'sd32768) begin
      sat_out = 16'sh8000;
    end else begin
      sat_out = sh[15:0];
    end
  endfunction

  // Datapath: products, accumulator and transposed state terms.
  always_comb begin
    p_b0_s = 32'(b_q[0]) * 32'(in);
    p_b1_s = 32'(b_q[1]) * 32'(in);
    p_b2_s = 32'(b_q[2]) * 32'(in);
    yacc_s = sat32(34'(p_b0_s) + 34'(s1_q));
    fb1_s  = fb_scale(48'(a_q[1]) * 48'(yacc_s));
    fb2_s  = fb_scale(48'(a_q[2]) * 48'(yacc_s));
    mid1_s = sat32(34'(p_b1_s) - 34'(fb1_s));
    mid2_s = sat32(34'(p_b2_s) - 34'(fb2_s));
  end

  // Next-state: run phase advances the filter, load phase holds it and steps the index.
  always_comb begin
    s1_d    = s1_q;
    s2_d    = s2_q;
    out_d   = out_q;
    idx_d   = idx_q;
    wr_en_s = 1'b0;
    if (load) begin
      s1_d  = sat32(34'(p_b1_s) - 34'(fb1_s) + 34'(s2_q));
      s2_d  = mid2_s;
      out_d = sat_out(yacc_s);
      idx_d = 2'd0;
    end else if (idx_q != 2'd3) begin
      wr_en_s = 1'b1;
      idx_d   = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // State and coefficient registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q[0] <= 16'sd0;
      a_q[1] <= 16'sd0;
      a_q[2] <= 16'sd0;
      b_q[0] <= 16'sd0;
      b_q[1] <= 16'sd0;
      b_q[2] <= 16'sd0;
      s1_q   <= 32'sd0;
      s2_q   <= 32'sd0;
      out_q  <= 16'sd0;
      idx_q  <= 2'd0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
      idx_q <= idx_d;
      if (wr_en_s) begin
        case (idx_q)
          2'd0: begin a_q[0] <= cina; b_q[0] <= cinb; end
          2'd1: begin a_q[1] <= cina; b_q[1] <= cinb; end
          2'd2: begin a_q[2] <= cina; b_q[2] <= cinb; end
          default: begin end
        endcase
      end
    end
  end

  assign out       = out_q;
  assign outa1w    = p_b0_s;
  assign outb1w    = mid1_s;
  assign outc1w    = mid2_s;
  assign del0w     = yacc_s;
  assign del2w     = s1_q;
  assign del3w     = s2_q;
  assign coeff_b0w = b_q[0];

endmodule

// File: tb/tb_my_iir_tran_core.sv
// Directed bench for my_iir_tran_core: expected outputs are queued at drive time
// and popped one clock later when the registered output is sampled.
module tb_my_iir_tran_core;

  logic               clk = 1'b0;
  logic               reset;
  logic               load;
  logic signed [15:0] in, cina, cinb;
  logic signed [15:0] out, coeff_b0w;
  logic signed [31:0] outa1w, outb1w, outc1w, del0w, del2w, del3w;

  int n_cmp = 0;
  int n_err = 0;
  logic signed [15:0] sb_q [$];

  my_iir_tran_core dut (
    .clk(clk), .reset(reset), .load(load), .in(in), .cina(cina), .cinb(cinb),
    .out(out), .outa1w(outa1w), .outb1w(outb1w), .outc1w(outc1w),
    .del0w(del0w), .del2w(del2w), .del3w(del3w), .coeff_b0w(coeff_b0w)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_coefs(input logic signed [15:0] b0, input logic signed [15:0] b1,
                            input logic signed [15:0] b2, input logic signed [15:0] a0,
                            input logic signed [15:0] a1, input logic signed [15:0] a2);
    load = 1'b0;
    cinb = b0; cina = a0; @(posedge clk); #1;
    cinb = b1; cina = a1; @(posedge clk); #1;
    cinb = b2; cina = a2; @(posedge clk); #1;
  endtask

  task automatic step(input string tag, input logic signed [15:0] x, input logic signed [15:0] y);
    logic signed [15:0] exp;
    in = x;
    load = 1'b1;
    sb_q.push_back(y);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'sd1, 32'sd0);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, out, exp);
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b1; in = 16'sd12345; cina = 16'sd0; cinb = 16'sd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 32'sd0);
    chk("rst_del2", del2w, 32'sd0);
    chk("rst_del3", del3w, 32'sd0);
    chk("rst_b0", coeff_b0w, 32'sd0);
    chk("rst_outa1", outa1w, 32'sd0);
    reset = 1'b1;

    // Passthrough
    load_coefs(16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 16'sd0, 16'sd0);
    in = 16'sd1000; #1;
    chk("pt_outa1", outa1w, 32'sd16384000);
    chk("pt_del0", del0w, 32'sd16384000);
    step("pt_1000", 16'sd1000, 16'sd1000);
    step("pt_m1234", -16'sd1234, -16'sd1234);

    // Unit delay
    load_coefs(16'sd0, 16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
    step("ud_0", 16'sd1000, 16'sd0);
    step("ud_1", 16'sd0, 16'sd1000);
    step("ud_2", 16'sd0, 16'sd0);
    step("ud_3", 16'sd0, 16'sd0);

    // Recursion y = x + 0.5*y[-1]
    load_coefs(16'sd16384, 16'sd0, 16'sd0, 16'sd16384, -16'sd8192, 16'sd0);
    step("rc_0", 16'sd1000, 16'sd1000);
    step("rc_1", 16'sd1000, 16'sd1500);
    step("rc_2", 16'sd1000, 16'sd1750);
    step("rc_3", 16'sd1000, 16'sd1875);

    // Freeze while reloading b0=8192; a 4th write must be ignored
    in = 16'sd7777;
    load_coefs(16'sd8192, 16'sd0, 16'sd0, 16'sd16384, -16'sd8192, 16'sd0);
    chk("frz_out", out, 32'sd1875);
    chk("frz_del2", del2w, 32'sd15360000);
    chk("frz_del3", del3w, 32'sd0);
    cinb = 16'sd5555; cina = 16'sd0;
    @(posedge clk); #1;
    chk("frz_b0_4th", coeff_b0w, 32'sd8192);
    chk("frz_out2", out, 32'sd1875);
    in = 16'sd1000; #1;
    chk("rs_del0", del0w, 32'sd23552000);
    step("rs_0", 16'sd1000, 16'sd1437);
    step("rs_1", 16'sd1000, 16'sd1218);

    // Asynchronous reset mid-run
    in = 16'sd1000; load = 1'b1;
    #3 reset = 1'b0;
    #1;
    chk("mrst_out", out, 32'sd0);
    chk("mrst_b0", coeff_b0w, 32'sd0);
    chk("mrst_del2", del2w, 32'sd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step("mrst_run", 16'sd1000, 16'sd0);

    // Output saturation
    load_coefs(16'sd32767, 16'sd0, 16'sd0, 16'sd16384, 16'sd0, 16'sd0);
    step("sat_pos", 16'sd30000, 16'sd32767);
    step("sat_neg", -16'sd30000, -16'sd32768);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
